nibble_serial_adder_seq: RTL and testbench

Sequencer that performs a WIDTH-bit addition by time-multiplexing one external 4-bit ripple-carry adder, one nibble per clock, LSB nibble first. It sits directly around the 4-bit adder: it feeds the adder's A/B/carry-in from captured operands and consumes its sum and carry-out into a result register. Upstream and downstream connect through valid/ready handshakes.

---
 rtl/nibble_serial_adder_seq.sv | 126 ++++++++++++
 tb/tb_nibble_serial_adder_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_seq.sv
// nibble_serial_adder_seq: WIDTH-bit adder built by time-multiplexing one
// external 4-bit ripple-carry adder, one nibble per clock, LSB nibble first.
// Operands come in and the result goes out over valid/ready handshakes. The
// result registers hold their values until the next operation completes.
module nibble_serial_adder_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_y,
  input  logic             add_cout
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = $clog2(NIBBLES) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr;
  // Only the top WIDTH-4 bits of the sum shift register are kept: the lowest
  // nibble would be shifted out on the final edge anyway.
  logic [WIDTH-5:0] sum_sr;
  logic [WIDTH-1:0] sum_full;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             last_nibble;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q, out_ovf_q;

  assign last_nibble = (cnt == CW'(NIBBLES - 1));
  // Value the sum shift register takes after absorbing the current adder nibble.
  assign sum_full    = {add_y, sum_sr};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_nx
    // unassigned and infers a latch.
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)    state_nx = RUN;
      RUN:     if (last_nibble) state_nx = DONE;
      DONE:    if (out_ready)   state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  // Operand capture, per-nibble shifting, carry propagation and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      sum_sr     <= '0;
      carry_q    <= 1'b0;
      cnt        <= '0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
      out_ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr    <= in_a;
            b_sr    <= in_b;
            carry_q <= in_cin;
            cnt     <= '0;
          end
        end
        RUN: begin
          sum_sr  <= sum_full[WIDTH-1:4];
          a_sr    <= a_sr >> 4;
          b_sr    <= b_sr >> 4;
          carry_q <= add_cout;
          cnt     <= cnt + 1'b1;
          if (last_nibble) begin
            out_sum_q  <= sum_full;
            out_cout_q <= add_cout;
            // Signed overflow: operands agree in sign, result sign differs.
            out_ovf_q  <= (a_sr[3] == b_sr[3]) && (add_y[3] != a_sr[3]);
          end
        end
        default: ;
      endcase
    end
  end

  // Adder feed: registers only, and forced to zero outside RUN.
  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_sr[3:0];
      add_b   = b_sr[3:0];
      add_cin = carry_q;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_seq.sv
// Directed and random bench for nibble_serial_adder_seq (WIDTH=16) with a
// behavioural 4-bit ripple-carry adder on the add_* ports.
module tb_nibble_serial_adder_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic [3:0]  add_a, add_b, add_y;
  logic        add_cin, add_cout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // External 4-bit adder.
  assign {add_cout, add_y} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  nibble_serial_adder_seq #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_y    (add_y),
    .add_cout (add_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer operands from IDLE; returns 1ns after the accepting edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic cin);
    check("ready_before_offer", 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid rises, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] s,
                              input logic c, input logic v);
    check({tag, "_sum"},  32'(out_sum),  32'(s));
    check({tag, "_cout"}, 32'(out_cout), 32'(c));
    check({tag, "_ovf"},  32'(out_ovf),  32'(v));
  endtask

  // Complete the output handshake and confirm the mandatory IDLE cycle.
  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, 32'(in_ready),  32'd1);
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [15:0] s, input logic c, input logic v);
    int lat;
    start_op(a, b, cin);
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check_result(tag, s, c, v);
    finish_op(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int results;
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] full;
    logic        exp_ovf;

    rst_n = 1'b0; in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF;
    in_cin = 1'b1; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state, with in_valid asserted to show nothing is captured.
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_cout",  32'(out_cout),  32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    check("rst_add_a",     32'(add_a),     32'd0);
    check("rst_add_b",     32'(add_b),     32'd0);
    check("rst_add_cin",   32'(add_cin),   32'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // First transaction, also checks the adder feed in the first RUN cycle.
    start_op(16'h1234, 16'h4321, 1'b0);
    check("run0_add_a",   32'(add_a),    32'h4);
    check("run0_add_b",   32'(add_b),    32'h1);
    check("run0_add_cin", 32'(add_cin),  32'd0);
    check("run0_ready",   32'(in_ready), 32'd0);
    wait_done(lat);
    check("basic_latency", 32'(lat), 32'd4);
    check_result("basic", 16'h5555, 1'b0, 1'b0);
    finish_op("basic");

    directed("wrap",      16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("carry_cin", 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0);
    directed("ovf_pos",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("ovf_neg",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Backpressure plus ignored offers during RUN and DONE.
    start_op(16'hA5A5, 16'h1111, 1'b0);
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF; in_cin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_run_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    check("bp_valid_rise", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_sum",   32'(out_sum),   32'hB6B6);
      check("bp_hold_ready", 32'(in_ready),  32'd0);
      in_a = 16'(i); in_b = 16'(i * 3);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_result("bp", 16'hB6B6, 1'b0, 1'b0);
    finish_op("bp");
    check("bp_idle_sum_held", 32'(out_sum), 32'hB6B6);
    directed("after_bp", 16'h0102, 16'h0304, 1'b0, 16'h0406, 1'b0, 1'b0);

    // Reset in the second RUN cycle.
    start_op(16'h1234, 16'h1111, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_sum",   32'(out_sum),   32'd0);
    check("mid_rst_add_a",     32'(add_a),     32'd0);
    check("mid_rst_add_b",     32'(add_b),     32'd0);
    #2 rst_n = 1'b1;
    directed("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Back-to-back random operations with random downstream readiness.
    results = 0;
    for (int n = 0; n < 200; n++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
      full    = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
      exp_ovf = (ra[15] == rb[15]) && (full[15] != ra[15]);
      start_op(ra, rb, rc);
      wait_done(lat);
      check("rand_latency", 32'(lat), 32'd4);
      check_result("rand", full[15:0], full[16], exp_ovf);
      for (int w = 0; w < 64; w++) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        if (out_ready) break;
        check("rand_stall_sum", 32'(out_sum), 32'(full[15:0]));
      end
      if (out_ready) results++;
      out_ready = 1'b0;
      check("rand_idle_valid", 32'(out_valid), 32'd0);
      if (!in_ready) begin
        // Handshake never completed; force one so the next offer starts in IDLE.
        finish_op("rand_force");
      end
    end
    check("rand_result_count", 32'(results), 32'd200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
